sram_puf_capture: RTL and testbench
===================================

Name: sram_puf_capture

Overview:
- Parametrised successor to the single-channel SRAM PUF byte store.
- Captures one frame of DEPTH words of SRAM start-up data streamed from the microprocessor, using a byte-valid strobe and an explicit frame start.
- Keeps two on-chip banks: bank 0 is the enrolled reference, bank 1 is the latest response.
- Computes the frame's ones-count (bias) and, in compare mode, the Hamming distance against the reference. Both banks are readable through a registered port for host and debug readout.

Parameters:
- DATA_W, 8: width of each streamed word.
- DEPTH, 64: words per frame; must equal 2**ADDR_W.
- ADDR_W, 6: address width of each bank.
- HW_W, 10: width of ones_cnt and hd_cnt; must be >= clog2(DEPTH*DATA_W+1).

Ports:
- uprocessor_clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- uprocessor_din  in  DATA_W  streamed SRAM word.
- uprocessor_valid  in  1  uprocessor_din is valid this cycle.
- frame_start  in  1  single-cycle pulse that begins a new capture.
- mode  in  1  sampled on frame_start; 0 = enrol (write bank 0), 1 = compare (write bank 1).
- rd_bank  in  1  readback bank select.
- rd_addr  in  ADDR_W  readback address.
- rd_data  out  DATA_W  readback data, 1-cycle latency.
- busy  out  1  high while capturing.
- done  out  1  one-cycle pulse when a frame completes.
- byte_cnt  out  ADDR_W+1  number of words captured in the current or last frame.
- ones_cnt  out  HW_W  total 1 bits in the current or last frame.
- hd_cnt  out  HW_W  Hamming distance from the reference (compare mode only).
- hd_valid  out  1  hd_cnt is meaningful for the last completed frame.
- ref_valid  out  1  bank 0 holds a complete enrolment.
- overflow  out  1  sticky; a stray valid word arrived outside a capture.

Behaviour:
- Reset (rst==0 at a clock edge) forces:
  - state IDLE;
  - busy, done, hd_valid, ref_valid, overflow = 0;
  - byte_cnt, ones_cnt, hd_cnt, rd_data = 0;
  - internal write address = 0.
  - Bank contents are not cleared.
  - Reset mid-capture abandons the frame.
- Banks: 2 x DEPTH x DATA_W register arrays.
  - Bank 0 has an internal combinational read at the write address, used for the distance calculation.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - On frame_start, go to CAPTURE and latch mode.
  - Clear wr_addr, byte_cnt, ones_cnt, hd_cnt, hd_valid and overflow.
  - If mode==0, also clear ref_valid.
- CAPTURE, on each uprocessor_valid:
  - Write din to bank[mode][wr_addr].
  - Increment wr_addr and byte_cnt.
  - ones_cnt += popcount(din).
  - If mode==1 and ref_valid, hd_cnt += popcount(din ^ bank0[wr_addr]).
  - When the write raises byte_cnt to DEPTH, go to DONE on the next edge.
- DONE: lasts exactly one cycle with done=1, then IDLE.
  - On entry: set ref_valid if mode==0; set hd_valid if mode==1 and ref_valid.
- busy=1 exactly while in CAPTURE.
- Counters and byte_cnt update live during a capture and hold their values after done until the next frame_start.
- wr_addr never wraps within a frame, because capture ends at DEPTH.
- frame_start during CAPTURE restarts the frame:
  - Counters are cleared and mode is re-latched.
  - A restart in enrol mode leaves ref_valid=0.
- frame_start and uprocessor_valid in the same cycle: frame_start wins; that word is discarded, not written, and does not set overflow.
- frame_start during DONE is honoured as in IDLE; done still pulses that cycle.
- uprocessor_valid in IDLE or DONE without frame_start:
  - No write and no count change.
  - overflow=1, held until the next frame_start or reset.
- Compare with ref_valid==0: the frame is captured into bank 1, hd_cnt stays 0 and hd_valid stays 0.
- Readback: rd_data <= bank[rd_bank][rd_addr] every cycle, independent of state.
  - Reading the location being written in the same cycle returns the old value.

Test Plan:
- Enrol: frame_start with mode=0, then 64 words of 0xA5 on consecutive cycles -> busy for 64 cycles; done pulses the cycle after the 64th write; ones_cnt=256, byte_cnt=64, ref_valid=1. Then rd_bank=0, rd_addr=5 -> rd_data=0xA5 one cycle later.
- Compare: after the enrol above, frame_start with mode=1, 64 words of 0x5A with gaps of 0-3 idle cycles -> ones_cnt=256, hd_cnt=512, hd_valid=1, ref_valid still 1; bank 1 address 63 reads 0x5A.
- Single-bit flip: compare with 0xA5 everywhere except word 3 = 0xA4 -> hd_cnt=1, ones_cnt=255.
- Abort: enrol 10 words, then frame_start with mode=0 asserted together with valid -> byte_cnt=0, ref_valid=0, busy=1, offending word not written. A further 64 words complete normally.
- Stray and reset: valid word in IDLE -> overflow=1, no memory change; cleared by the next frame_start. rst=0 at word 30 of a capture -> all outputs 0 the next cycle and state IDLE. A subsequent compare frame -> hd_valid=0, hd_cnt=0.

Source files
------------

// File: rtl/sram_puf_capture.sv
// SRAM PUF frame capture: enrols a reference frame into bank 0, captures compare frames
// into bank 1, and accumulates the frame's ones-count and Hamming distance to the reference.
module sram_puf_capture #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned HW_W   = 10
) (
    input  logic              uprocessor_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] uprocessor_din,
    input  logic              uprocessor_valid,
    input  logic              frame_start,
    input  logic              mode,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   byte_cnt,
    output logic [HW_W-1:0]   ones_cnt,
    output logic [HW_W-1:0]   hd_cnt,
    output logic              hd_valid,
    output logic              ref_valid,
    output logic              overflow
);

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]     byte_cnt_q, byte_cnt_d;
    logic [HW_W-1:0]     ones_cnt_q, ones_cnt_d;
    logic [HW_W-1:0]     hd_cnt_q, hd_cnt_d;
    logic                hd_valid_q, hd_valid_d;
    logic                ref_valid_q, ref_valid_d;
    logic                overflow_q, overflow_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [DATA_W-1:0]   bank0_q [DEPTH];
    logic [DATA_W-1:0]   bank1_q [DEPTH];
    logic                we0, we1;
    logic [DATA_W-1:0]   ref_word;

    function automatic logic [HW_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [HW_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            c = c + HW_W'(v[i]);
        end
        return c;
    endfunction

    // Reference word aligned with the word currently being captured.
    assign ref_word = bank0_q[wr_addr_q];

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wr_addr_d   = wr_addr_q;
        byte_cnt_d  = byte_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        hd_cnt_d    = hd_cnt_q;
        hd_valid_d  = hd_valid_q;
        ref_valid_d = ref_valid_q;
        overflow_d  = overflow_q;
        we0         = 1'b0;
        we1         = 1'b0;
        rd_data_d   = rd_bank ? bank1_q[rd_addr] : bank0_q[rd_addr];

        if (frame_start) begin
            // A start from any state (re)opens a frame; a coincident word is dropped.
            state_d    = StCapture;
            mode_d     = mode;
            wr_addr_d  = '0;
            byte_cnt_d = '0;
            ones_cnt_d = '0;
            hd_cnt_d   = '0;
            hd_valid_d = 1'b0;
            overflow_d = 1'b0;
            if (!mode) begin
                ref_valid_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (uprocessor_valid) begin
                        overflow_d = 1'b1;
                    end
                end
                StCapture: begin
                    if (uprocessor_valid) begin
                        we0        = ~mode_q;
                        we1        = mode_q;
                        wr_addr_d  = wr_addr_q + 1'b1;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        ones_cnt_d = ones_cnt_q + popcount(uprocessor_din);
                        if (mode_q && ref_valid_q) begin
                            hd_cnt_d = hd_cnt_q + popcount(uprocessor_din ^ ref_word);
                        end
                        if (byte_cnt_d == DepthCnt) begin
                            state_d = StDone;
                            if (!mode_q) begin
                                ref_valid_d = 1'b1;
                            end else if (ref_valid_q) begin
                                hd_valid_d = 1'b1;
                            end
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    if (uprocessor_valid) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge uprocessor_clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            wr_addr_q   <= '0;
            byte_cnt_q  <= '0;
            ones_cnt_q  <= '0;
            hd_cnt_q    <= '0;
            hd_valid_q  <= 1'b0;
            ref_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            wr_addr_q   <= wr_addr_d;
            byte_cnt_q  <= byte_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            hd_cnt_q    <= hd_cnt_d;
            hd_valid_q  <= hd_valid_d;
            ref_valid_q <= ref_valid_d;
            overflow_q  <= overflow_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Bank contents survive reset; reset only blocks the write.
    always_ff @(posedge uprocessor_clk) begin
        if (rst && we0) begin
            bank0_q[wr_addr_q] <= uprocessor_din;
        end
        if (rst && we1) begin
            bank1_q[wr_addr_q] <= uprocessor_din;
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = (state_q == StCapture);
    assign done      = (state_q == StDone);
    assign byte_cnt  = byte_cnt_q;
    assign ones_cnt  = ones_cnt_q;
    assign hd_cnt    = hd_cnt_q;
    assign hd_valid  = hd_valid_q;
    assign ref_valid = ref_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sram_puf_capture.sv
// Directed bench for sram_puf_capture: enrol, compare, bit flip, abort, stray word and reset.
module tb_sram_puf_capture;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       valid;
    logic       frame_start;
    logic       mode;
    logic       rd_bank;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [6:0] byte_cnt;
    logic [9:0] ones_cnt;
    logic [9:0] hd_cnt;
    logic       hd_valid;
    logic       ref_valid;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cycles;

    sram_puf_capture #(
        .DATA_W(8),
        .DEPTH (64),
        .ADDR_W(6),
        .HW_W  (10)
    ) dut (
        .uprocessor_clk  (clk),
        .rst             (rst),
        .uprocessor_din  (din),
        .uprocessor_valid(valid),
        .frame_start     (frame_start),
        .mode            (mode),
        .rd_bank         (rd_bank),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .byte_cnt        (byte_cnt),
        .ones_cnt        (ones_cnt),
        .hd_cnt          (hd_cnt),
        .hd_valid        (hd_valid),
        .ref_valid       (ref_valid),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic m);
        frame_start = 1'b1;
        mode        = m;
        step();
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        valid = 1'b1;
        din   = w;
        step();
        valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic b, input logic [5:0] a,
                              input logic [7:0] exp);
        rd_bank = b;
        rd_addr = a;
        step();
        check(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b0; din = '0; valid = 1'b0; frame_start = 1'b0; mode = 1'b0;
        rd_bank = 1'b0; rd_addr = '0;
        repeat (3) step();
        rst = 1'b1;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        check("rst_ones", ones_cnt, 0);
        check("rst_hd", hd_cnt, 0);
        check("rst_hd_valid", hd_valid, 0);
        check("rst_ref_valid", ref_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rd_data", rd_data, 0);

        // Enrol 64 x 0xA5 on consecutive cycles
        start_frame(1'b0);
        busy_cycles = busy ? 1 : 0;
        for (int i = 0; i < 64; i++) begin
            send_word(8'hA5);
            busy_cycles += busy ? 1 : 0;
        end
        check("enrol_busy_cycles", busy_cycles, 64);
        check("enrol_done", done, 1);
        check("enrol_ones", ones_cnt, 256);
        check("enrol_byte_cnt", byte_cnt, 64);
        check("enrol_ref_valid", ref_valid, 1);
        check("enrol_hd_valid", hd_valid, 0);
        step();
        check("enrol_done_pulse", done, 0);
        read_check("enrol_rd_b0_a5", 1'b0, 6'd5, 8'hA5);

        // Compare 64 x 0x5A with 0-3 idle gaps
        start_frame(1'b1);
        for (int i = 0; i < 64; i++) begin
            repeat (i % 4) step();
            send_word(8'h5A);
        end
        check("cmp_done", done, 1);
        check("cmp_ones", ones_cnt, 256);
        check("cmp_hd", hd_cnt, 512);
        check("cmp_hd_valid", hd_valid, 1);
        check("cmp_ref_valid", ref_valid, 1);
        step();
        read_check("cmp_rd_b1_a63", 1'b1, 6'd63, 8'h5A);

        // Single-bit flip at word 3
        start_frame(1'b1);
        for (int i = 0; i < 64; i++) begin
            send_word((i == 3) ? 8'hA4 : 8'hA5);
        end
        check("flip_hd", hd_cnt, 1);
        check("flip_ones", ones_cnt, 255);
        check("flip_hd_valid", hd_valid, 1);
        step();

        // Abort: restart an enrol with a coincident valid word
        start_frame(1'b0);
        for (int i = 0; i < 10; i++) begin
            send_word(8'h11);
        end
        check("abort_pre_byte_cnt", byte_cnt, 10);
        frame_start = 1'b1; mode = 1'b0; valid = 1'b1; din = 8'hEE;
        step();
        frame_start = 1'b0; valid = 1'b0;
        check("abort_byte_cnt", byte_cnt, 0);
        check("abort_ref_valid", ref_valid, 0);
        check("abort_busy", busy, 1);
        check("abort_ones", ones_cnt, 0);
        check("abort_overflow", overflow, 0);
        read_check("abort_b0_a10_kept", 1'b0, 6'd10, 8'hA5);
        read_check("abort_b0_a0", 1'b0, 6'd0, 8'h11);
        for (int i = 0; i < 64; i++) begin
            send_word(8'h3C);
        end
        check("abort_fin_done", done, 1);
        check("abort_fin_byte_cnt", byte_cnt, 64);
        check("abort_fin_ones", ones_cnt, 256);
        check("abort_fin_ref_valid", ref_valid, 1);
        step();
        read_check("abort_fin_b0_a10", 1'b0, 6'd10, 8'h3C);

        // Stray word in idle
        send_word(8'hFF);
        check("stray_overflow", overflow, 1);
        check("stray_byte_cnt", byte_cnt, 64);
        check("stray_ones", ones_cnt, 256);
        read_check("stray_b0_a0", 1'b0, 6'd0, 8'h3C);
        read_check("stray_b1_a0", 1'b1, 6'd0, 8'hA5);
        check("stray_overflow_held", overflow, 1);

        // Compare frame reset at word 30
        start_frame(1'b1);
        check("start_clr_overflow", overflow, 0);
        for (int i = 0; i < 30; i++) begin
            send_word(8'h00);
        end
        check("pre_rst_byte_cnt", byte_cnt, 30);
        rd_bank = 1'b1; rd_addr = 6'd63;
        rst = 1'b0; valid = 1'b1; din = 8'h00;
        step();
        rst = 1'b1; valid = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_byte_cnt", byte_cnt, 0);
        check("mrst_ones", ones_cnt, 0);
        check("mrst_hd", hd_cnt, 0);
        check("mrst_ref_valid", ref_valid, 0);
        check("mrst_rd_data", rd_data, 0);
        step();
        check("mrst_idle", busy, 0);
        check("mrst_rd_resumes", rd_data, 8'hA5);

        // Compare without reference
        start_frame(1'b1);
        for (int i = 0; i < 64; i++) begin
            send_word(8'hFF);
        end
        check("noref_done", done, 1);
        check("noref_ones", ones_cnt, 512);
        check("noref_hd", hd_cnt, 0);
        check("noref_hd_valid", hd_valid, 0);
        check("noref_ref_valid", ref_valid, 0);
        step();
        read_check("noref_b1_a40", 1'b1, 6'd40, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
